// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
//
// Writeback queue placed directly upstream of the integer register file.
// Completed results arrive over a valid/ready handshake. They are buffered in
// a small in-order FIFO and then drained, one per cycle, onto the register
// file's single write port. An external (debug) writer takes priority on that
// port. Pending writes are visible through two forwarding query ports. A
// 32-bit counter records every accepted handshake.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous reset, active low (0 = reset)
//   in_valid / in_ready      upstream handshake
//   in_wen, in_rd, in_data   result: write enable, destination index, value
//   ext_wen/ext_waddr/ext_wdata  priority external write request
//   rf_wen/rf_waddr/rf_wdata register file write port
//   q_raddr1/2               forwarding query indices
//   q_hit1/2, q_data1/2      pending-write hit flag and youngest pending value
//   retired                  count of accepted handshakes (wraps)
// -----------------------------------------------------------------------------
module wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wen,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  ext_wen,
    input  logic [ADDR_WIDTH-1:0] ext_waddr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] q_raddr1,
    input  logic [ADDR_WIDTH-1:0] q_raddr2,
    output logic                  q_hit1,
    output logic                  q_hit2,
    output logic [DATA_WIDTH-1:0] q_data1,
    output logic [DATA_WIDTH-1:0] q_data2,
    output logic [31:0]           retired
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [COUNT_W-1:0]    count_r;
    logic                  active_r;
    logic [31:0]           retired_r;

    logic                  accept_s;
    logic                  enq_s;
    logic                  deq_s;
    logic                  not_empty_s;

    // Youngest valid entry whose destination matches the query index.
    // Entries are scanned oldest to youngest so later matches override.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(
        input logic [ADDR_WIDTH-1:0] qa,
        input logic [PTR_W-1:0]      head,
        input logic [COUNT_W-1:0]    cnt,
        input logic [ADDR_WIDTH-1:0] amem [DEPTH],
        input logic [DATA_WIDTH-1:0] dmem [DEPTH]
    );
        logic                  hit;
        logic [DATA_WIDTH-1:0] val;
        logic [PTR_W-1:0]      idx;
        hit = 1'b0;
        val = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((COUNT_W'(i) < cnt) && (qa != {ADDR_WIDTH{1'b0}}) && (amem[idx] == qa)) begin
                hit = 1'b1;
                val = dmem[idx];
            end else begin
                hit = hit;
            end
        end
        return {hit, val};
    endfunction

    // Handshake and FIFO movement decisions.
    always_comb begin
        not_empty_s = (count_r != {COUNT_W{1'b0}});
        in_ready    = active_r & (count_r < COUNT_W'(DEPTH));
        accept_s    = in_valid & in_ready;
        enq_s       = accept_s & in_wen & (in_rd != {ADDR_WIDTH{1'b0}});
        deq_s       = rst & ~ext_wen & not_empty_s;
    end

    // Write-port arbitration: external writer first, then queue head.
    // Held quiet while reset is asserted so nothing leaks to the register file.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = {ADDR_WIDTH{1'b0}};
        rf_wdata = {DATA_WIDTH{1'b0}};
        if (!rst) begin
            rf_wen = 1'b0;
        end else if (ext_wen) begin
            rf_wen   = 1'b1;
            rf_waddr = ext_waddr;
            rf_wdata = ext_wdata;
        end else if (not_empty_s) begin
            rf_wen   = 1'b1;
            rf_waddr = addr_mem_r[rd_ptr_r];
            rf_wdata = data_mem_r[rd_ptr_r];
        end else begin
            rf_wen = 1'b0;
        end
    end

    // Forwarding queries over stored entries only.
    always_comb begin
        {q_hit1, q_data1} = fwd_lookup(q_raddr1, rd_ptr_r, count_r, addr_mem_r, data_mem_r);
        {q_hit2, q_data2} = fwd_lookup(q_raddr2, rd_ptr_r, count_r, addr_mem_r, data_mem_r);
    end

    // Pointer, occupancy, ready-enable and retirement state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {COUNT_W{1'b0}};
            active_r  <= 1'b0;
            retired_r <= 32'd0;
        end else begin
            active_r <= 1'b1;
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + COUNT_W'(1);
                2'b01:   count_r <= count_r - COUNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (accept_s) begin
                retired_r <= retired_r + 32'd1;
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Entry storage; cleared on reset so stale contents never surface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_WIDTH{1'b0}};
                data_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (enq_s) begin
            addr_mem_r[wr_ptr_r] <= in_rd;
            data_mem_r[wr_ptr_r] <= in_data;
        end else begin
            addr_mem_r[wr_ptr_r] <= addr_mem_r[wr_ptr_r];
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
        end
    end

    assign retired = retired_r;

endmodule

// File: tb/tb_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_queue
//
// Scoreboard bench for wb_queue. Each directed test pushes the register-file
// writes it expects, in order, into a queue; a monitor running on the falling
// edge pops one entry for every cycle rf_wen is high and compares it. Other
// observable state (ready, retired, forwarding) is checked inline.
// -----------------------------------------------------------------------------
module tb_wb_queue;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_wen;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          ext_wen;
    logic [AW-1:0] ext_waddr;
    logic [DW-1:0] ext_wdata;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] q_raddr1;
    logic [AW-1:0] q_raddr2;
    logic          q_hit1;
    logic          q_hit2;
    logic [DW-1:0] q_data1;
    logic [DW-1:0] q_data2;
    logic [31:0]   retired;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wen(in_wen), .in_rd(in_rd), .in_data(in_data),
        .ext_wen(ext_wen), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_raddr1(q_raddr1), .q_raddr2(q_raddr2),
        .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every register-file write must match the next expected one.
    always @(negedge clk) begin
        if (rst && rf_wen) begin
            wr_t w;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rf_unexpected: got addr=%0d data=0x%08h expected no write",
                         rf_waddr, rf_wdata);
            end else begin
                w = exp_q.pop_front();
                if (rf_waddr !== w.addr || rf_wdata !== w.data) begin
                    failures++;
                    $display("FAIL rf_write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                             rf_waddr, rf_wdata, w.addr, w.data);
                end
            end
        end
    end

    // One handshake; called right after a rising edge (+1), returns likewise.
    task automatic send(input logic wen, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        int waited;
        in_valid = 1'b1;
        in_wen   = wen;
        in_rd    = rd;
        in_data  = d;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_wen   = 1'b0;
        in_rd    = '0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_rd = '0; in_data = '0;
        ext_wen = 1'b0; ext_waddr = '0; ext_wdata = '0; q_raddr1 = '0; q_raddr2 = '0;

        // Reset state
        idle(2);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_rf_wen",   {31'd0, rf_wen},   32'd0);
        check("reset_retired",  retired,           32'd0);
        rst = 1'b1;
        check("ready_low_at_release", {31'd0, in_ready}, 32'd0);
        idle(1);
        check("ready_after_release", {31'd0, in_ready}, 32'd1);

        // Single accept and one-cycle latency
        expect_wr(5'd5, 32'h1234_5678);
        send(1'b1, 5'd5, 32'h1234_5678);
        @(negedge clk);
        check("t1_rf_wen",   {31'd0, rf_wen}, 32'd1);
        check("t1_retired",  retired,         32'd1);
        @(negedge clk);
        check("t1_rf_idle",  {31'd0, rf_wen}, 32'd0);
        idle(1);

        // Non-writing transfers consume a slot in retired only
        send(1'b0, 5'd9, 32'hDEAD_BEEF);
        send(1'b1, 5'd0, 32'hCAFE_F00D);
        idle(3);
        check("t2_retired", retired, 32'd3);
        check("t2_no_writes", exp_q.size(), 32'd0);

        // External stall for 4 cycles while streaming rd=1,2,3
        repeat (4) expect_wr(5'd10, 32'hE0E0_0001);
        expect_wr(5'd1, 32'h0000_0011);
        expect_wr(5'd2, 32'h0000_0022);
        expect_wr(5'd3, 32'h0000_0033);
        ext_waddr = 5'd10; ext_wdata = 32'hE0E0_0001; ext_wen = 1'b1;
        q_raddr1 = 5'd2;
        fork
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("t3_full_ready", {31'd0, in_ready}, 32'd0);
                check("t3_fwd_hit",    {31'd0, q_hit1},   32'd1);
                check("t3_fwd_data",   q_data1,           32'h0000_0022);
                repeat (2) @(posedge clk);
                #1;
                ext_wen = 1'b0;
            end
            begin
                send(1'b1, 5'd1, 32'h0000_0011);
                send(1'b1, 5'd2, 32'h0000_0022);
                send(1'b1, 5'd3, 32'h0000_0033);
            end
        join
        idle(4);
        check("t3_drained", exp_q.size(), 32'd0);
        check("t3_retired", retired, 32'd6);

        // Forwarding returns the youngest of two writes to the same register
        repeat (3) expect_wr(5'd4, 32'h4444_0000);
        expect_wr(5'd7, 32'hAAAA_AAAA);
        expect_wr(5'd7, 32'hBBBB_BBBB);
        ext_waddr = 5'd4; ext_wdata = 32'h4444_0000; ext_wen = 1'b1;
        q_raddr1 = 5'd7; q_raddr2 = 5'd0;
        send(1'b1, 5'd7, 32'hAAAA_AAAA);
        send(1'b1, 5'd7, 32'hBBBB_BBBB);
        @(negedge clk);
        check("t4_hit1",  {31'd0, q_hit1}, 32'd1);
        check("t4_data1", q_data1,         32'hBBBB_BBBB);
        check("t4_hit2",  {31'd0, q_hit2}, 32'd0);
        check("t4_data2", q_data2,         32'd0);
        q_raddr2 = 5'd3;
        #1;
        check("t4_miss_hit2", {31'd0, q_hit2}, 32'd0);
        @(posedge clk);
        #1;
        ext_wen = 1'b0;
        idle(4);
        check("t4_drained", exp_q.size(), 32'd0);
        check("t4_empty_hit", {31'd0, q_hit1}, 32'd0);

        // Asynchronous reset with a full queue: buffered entries are dropped
        repeat (2) expect_wr(5'd8, 32'h8888_8888);
        ext_waddr = 5'd8; ext_wdata = 32'h8888_8888; ext_wen = 1'b1;
        send(1'b1, 5'd12, 32'h1212_1212);
        send(1'b1, 5'd13, 32'h1313_1313);
        check("t5_full", {31'd0, in_ready}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("t5_rst_rf_wen",   {31'd0, rf_wen},   32'd0);
        check("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("t5_rst_retired",  retired,           32'd0);
        check("t5_rst_hit",      {31'd0, q_hit1},   32'd0);
        idle(2);
        ext_wen = 1'b0;
        rst = 1'b1;
        idle(5);
        check("t5_no_stale", exp_q.size(), 32'd0);
        check("t5_ready",    {31'd0, in_ready}, 32'd1);

        // Retired counter wraps from all-ones to zero
        @(negedge clk);
        force dut.retired_r = 32'hFFFF_FFFF;
        #1;
        release dut.retired_r;
        @(posedge clk);
        #1;
        check("t6_preload", retired, 32'hFFFF_FFFF);
        send(1'b0, 5'd1, 32'd0);
        check("t6_wrap", retired, 32'd0);

        idle(3);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue placed directly upstream of the integer register file. It accepts completed results from the execute/load stage over a valid/ready handshake, buffers them in a small in-order FIFO, and drives the register file's single write port one entry per cycle. A debug/external writer has priority on that port. The block also provides forwarding and busy flags for pending writes, and keeps a retired-instruction counter.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width
- DEPTH, 2, FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- in_valid  in  1  upstream result valid
- in_ready  out  1  queue can accept
- in_wen  in  1  instruction writes rd
- in_rd  in  ADDR_WIDTH  destination register
- in_data  in  DATA_WIDTH  result value
- ext_wen  in  1  external write request (priority)
- ext_waddr  in  ADDR_WIDTH  external write index
- ext_wdata  in  DATA_WIDTH  external write data
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write index
- rf_wdata  out  DATA_WIDTH  register file write data
- q_raddr1, q_raddr2  in  ADDR_WIDTH  forwarding query indices
- q_hit1, q_hit2  out  1  pending write to queried register
- q_data1, q_data2  out  DATA_WIDTH  youngest pending value for that register, 0 if no hit
- retired  out  32  count of accepted handshakes

## Operation
- Accept: in_valid & in_ready. Every accepted transfer increments retired (wraps 2^32-1 -> 0), whether or not it writes.
- Enqueue only when in_wen=1 and in_rd!=0; otherwise transfer is consumed, nothing stored.
- in_ready = (count < DEPTH) & rst deasserted; registered-state only, no combinational path from in_valid or ext_wen.
- Port arbitration each cycle: ext_wen=1 -> rf_wen=1, rf_waddr/rf_wdata = ext_*; head not dequeued. Else if count>0 -> rf_* = head entry, rf_wen=1, head dequeued at clock edge. Else rf_wen=0, rf_waddr=0, rf_wdata=0.
- ext_wen with ext_waddr=0 still occupies the port (register file discards it).
- Simultaneous enqueue and dequeue: count unchanged; pointers both advance.
- Forwarding: q_hitN=1 iff q_raddrN!=0 and some valid entry has matching rd; q_dataN from youngest match. Queries combinational on stored entries only (not on in_*). Entry being written this cycle still counts as hit.
- Pointers wrap modulo DEPTH; count held as 0..DEPTH.

## Timing
- Reset (rst=0, async): count=0, pointers=0, retired=0, in_ready=0, rf_wen=0, rf_waddr=0, rf_wdata=0, q_hit*=0, q_data*=0. in_ready rises to 1 the first cycle after rst goes 1.
- Reset mid-operation: all buffered entries discarded, never written; no rf_wen during or after reset until new accepts.
- Latency: entry accepted at edge E appears on rf_* during the following cycle and is written at edge E+1, if no ext_wen.
- Throughput: one accept and one drain per cycle; full only while ext_wen stalls draining.
- Full (count=DEPTH): in_ready=0; upstream must hold in_valid/data stable.
- retired updates at the accept edge; value visible next cycle.

## Test plan
- Reset then single accept in_wen=1,in_rd=5,in_data=0x12345678 -> next cycle rf_wen=1,rf_waddr=5,rf_wdata=0x12345678; retired=1; following cycle rf_wen=0.
- Accept in_rd=0 and in_wen=0 transfers -> no rf_wen ever; retired increments by 2.
- Hold ext_wen=1 for 4 cycles while streaming rd=1,2,3 -> in_ready drops after 2 accepts; after ext_wen drops, writes rd=1,2,3 in order on consecutive cycles.
- Queue rd=7 data A then rd=7 data B under ext_wen stall, q_raddr1=7 -> q_hit1=1,q_data1=B; q_raddr2=0 -> q_hit2=0,q_data2=0.
- Fill queue (count=2), assert rst=0 asynchronously mid-cycle -> rf_wen=0 immediately, in_ready=0, retired=0; after release no stale writes.
- Preload 0xFFFFFFFF accepts (or force) then one accept -> retired wraps to 0.
